// File: rtl/mul_div_unit_pkg.sv
// Shared types and helpers for the iterative RV64M multiply/divide unit.
package mul_div_unit_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    MD_MUL  = 3'd0,
    MD_DIV  = 3'd1,
    MD_DIVU = 3'd2,
    MD_REM  = 3'd3,
    MD_REMU = 3'd4
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } md_state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Word results are always sign-extended from bit 31, including DIVUW/REMUW.
  function automatic logic [XLEN-1:0] fmt_result(input logic word, input logic [XLEN-1:0] v);
    if (word) begin
      return sext32(v[31:0]);
    end else begin
      return v;
    end
  endfunction

  function automatic logic [XLEN-1:0] prep_operand(input md_op_t op, input logic word,
                                                   input logic [XLEN-1:0] src);
    if (!word) begin
      return src;
    end else if (op == MD_DIVU || op == MD_REMU) begin
      return {32'd0, src[31:0]};
    end else begin
      return sext32(src[31:0]);
    end
  endfunction

endpackage

// File: rtl/mul_div_unit_divider.sv
// Unsigned restoring divider core: one quotient bit per cycle for i_iter cycles.
module md_divider
  import mul_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_abort,
  input  logic            i_start,
  input  logic [6:0]      i_iter,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder,
  output logic            o_done
);

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_divisor;
  logic [6:0]      r_iter;
  logic [5:0]      r_cnt;
  logic            r_active;

  logic [XLEN+1:0] w_shift;
  logic [XLEN+1:0] w_trial;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;

  // One restoring step; extra top bits catch the borrow of the trial subtract.
  always_comb begin
    w_shift   = {1'b0, r_rem, r_quo[XLEN-1]};
    w_trial   = w_shift - {2'b00, r_divisor};
    w_ge      = ~w_trial[XLEN+1];
    w_rem_nxt = w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
    w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
  end

  assign o_quotient  = w_quo_nxt;
  assign o_remainder = w_rem_nxt;
  assign o_done      = r_active && ({1'b0, r_cnt} == (r_iter - 7'd1));

  // Word divides pre-align the dividend so the first step sees bit 31.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_iter    <= 7'd0;
      r_cnt     <= 6'd0;
      r_active  <= 1'b0;
    end else if (i_abort) begin
      r_active <= 1'b0;
      r_cnt    <= 6'd0;
    end else if (i_start) begin
      r_rem     <= '0;
      r_quo     <= i_dividend << (7'd64 - i_iter);
      r_divisor <= i_divisor;
      r_iter    <= i_iter;
      r_cnt     <= 6'd0;
      r_active  <= 1'b1;
    end else if (r_active) begin
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_cnt    <= r_cnt + 6'd1;
      r_active <= ~o_done;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, sign fix-up.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  md_op_t          op,
  input  logic            word,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_t       r_state;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic [5:0]      r_cnt;
  logic [5:0]      r_last;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic            r_word;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;

  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_is_mul;
  logic            w_is_div;
  logic            w_is_rem;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_accept;
  logic            w_div_start;
  logic [XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic            w_div_done;
  logic [XLEN-1:0] w_div_res;

  // Operand preparation and divide special-case detection at accept.
  always_comb begin
    w_a           = prep_operand(op, word, src_a);
    w_b           = prep_operand(op, word, src_b);
    w_signed      = (op == MD_DIV) || (op == MD_REM);
    w_a_neg       = w_signed && w_a[XLEN-1];
    w_b_neg       = w_signed && w_b[XLEN-1];
    w_a_abs       = w_a_neg ? (64'd0 - w_a) : w_a;
    w_b_abs       = w_b_neg ? (64'd0 - w_b) : w_b;
    w_is_mul      = (op == MD_MUL);
    w_is_rem      = (op == MD_REM) || (op == MD_REMU);
    w_is_div      = w_signed || (op == MD_DIVU) || (op == MD_REMU);
    w_special     = 1'b0;
    w_special_res = '0;
    if (w_b == 64'd0) begin
      w_special     = 1'b1;
      w_special_res = fmt_result(word, w_is_rem ? w_a : 64'hFFFF_FFFF_FFFF_FFFF);
    end else if (w_signed && (w_b == 64'hFFFF_FFFF_FFFF_FFFF) &&
                 (w_a == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000))) begin
      w_special     = 1'b1;
      w_special_res = fmt_result(word, w_is_rem ? 64'd0 : w_a);
    end else begin
      w_special     = 1'b0;
      w_special_res = '0;
    end
    w_accept    = (r_state == ST_IDLE) && start && !flush && (w_is_mul || w_is_div);
    w_div_start = w_accept && w_is_div && !w_special;
  end

  // Datapath step values consumed by the FSM, including the final divide sign fix-up.
  always_comb begin
    w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    if (r_is_rem) begin
      w_div_res = fmt_result(r_word, r_neg_r ? (64'd0 - w_rem) : w_rem);
    end else begin
      w_div_res = fmt_result(r_word, r_neg_q ? (64'd0 - w_quo) : w_quo);
    end
  end

  md_divider u_divider (
    .clk        (clk),
    .resetn     (resetn),
    .i_abort    (flush),
    .i_start    (w_div_start),
    .i_iter     (word ? 7'd32 : 7'd64),
    .i_dividend (w_a_abs),
    .i_divisor  (w_b_abs),
    .o_quotient (w_quo),
    .o_remainder(w_rem),
    .o_done     (w_div_done)
  );

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cnt    <= 6'd0;
      r_last   <= 6'd0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_word   <= 1'b0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_word   <= word;
            r_is_rem <= w_is_rem;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_cnt    <= 6'd0;
            r_last   <= word ? 6'd31 : 6'd63;
            r_acc    <= '0;
            r_mcand  <= w_a;
            r_mplier <= w_b;
            if (w_is_mul) begin
              r_state <= ST_MUL;
            end else if (w_special) begin
              r_state  <= ST_FIN;
              r_done   <= 1'b1;
              r_result <= w_special_res;
            end else begin
              r_state <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 6'd1;
          if (r_cnt == r_last) begin
            r_state  <= ST_FIN;
            r_done   <= 1'b1;
            r_result <= fmt_result(r_word, w_acc_nxt);
          end
        end
        ST_DIV: begin
          if (w_div_done) begin
            r_state  <= ST_FIN;
            r_done   <= 1'b1;
            r_result <= w_div_res;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = r_ready;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized ops against an arithmetic model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  md_op_t      op = MD_MUL;
  logic        word = 1'b0;
  logic [63:0] src_a = 64'd0;
  logic [63:0] src_b = 64'd0;
  logic        flush = 1'b0;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int n_vec = 0;
  int n_err = 0;

  mul_div_unit dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .word(word),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics computed with native arithmetic.
  function automatic logic [63:0] ref_result(input md_op_t o, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    longint      sa;
    longint      sb;
    int          xa;
    int          xb;
    logic [31:0] r32;
    logic [63:0] r64;
    sa = a; sb = b; xa = a[31:0]; xb = b[31:0]; r32 = 32'd0; r64 = 64'd0;
    if (w) begin
      case (o)
        MD_MUL: r32 = xa * xb;
        MD_DIV: begin
          if (xb == 32'sd0) r32 = 32'hFFFF_FFFF;
          else if (xa == 32'sh8000_0000 && xb == -32'sd1) r32 = xa;
          else r32 = xa / xb;
        end
        MD_DIVU: begin
          if (b[31:0] == 32'd0) r32 = 32'hFFFF_FFFF;
          else r32 = a[31:0] / b[31:0];
        end
        MD_REM: begin
          if (xb == 32'sd0) r32 = xa;
          else if (xa == 32'sh8000_0000 && xb == -32'sd1) r32 = 32'd0;
          else r32 = xa % xb;
        end
        MD_REMU: begin
          if (b[31:0] == 32'd0) r32 = a[31:0];
          else r32 = a[31:0] % b[31:0];
        end
        default: r32 = 32'd0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (o)
      MD_MUL: r64 = a * b;
      MD_DIV: begin
        if (sb == 64'sd0) r64 = 64'hFFFF_FFFF_FFFF_FFFF;
        else if (sa == 64'sh8000_0000_0000_0000 && sb == -64'sd1) r64 = a;
        else r64 = sa / sb;
      end
      MD_DIVU: begin
        if (b == 64'd0) r64 = 64'hFFFF_FFFF_FFFF_FFFF;
        else r64 = a / b;
      end
      MD_REM: begin
        if (sb == 64'sd0) r64 = a;
        else if (sa == 64'sh8000_0000_0000_0000 && sb == -64'sd1) r64 = 64'd0;
        else r64 = sa % sb;
      end
      MD_REMU: begin
        if (b == 64'd0) r64 = a;
        else r64 = a % b;
      end
      default: r64 = 64'd0;
    endcase
    return r64;
  endfunction

  function automatic int ref_latency(input md_op_t o, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    logic div0;
    logic ovf;
    if (o == MD_MUL) return w ? 33 : 65;
    div0 = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = (o == MD_DIV || o == MD_REM) &&
           (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
              : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (div0 || ovf) return 1;
    return w ? 33 : 65;
  endfunction

  // Issue one op, count cycles from the accept edge to done, and check the outcome.
  task automatic run_op(input md_op_t o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic poke, output logic [63:0] res);
    int          cyc;
    int          exp_l;
    logic        busy_ok;
    logic [63:0] exp_r;
    exp_r = ref_result(o, w, a, b);
    exp_l = ref_latency(o, w, a, b);
    @(negedge clk);
    op = o; word = w; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1 || ready !== 1'b0) busy_ok = 1'b0;
      if (poke && cyc == 3) begin
        start = 1'b1;
        op    = md_op_t'($urandom_range(4, 0));
        word  = 1'($urandom);
        src_a = {$urandom, $urandom};
        src_b = {$urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("busy_during_op", 64'(busy_ok), 64'd1);
    chk("latency", 64'(cyc), 64'(exp_l));
    chk("result", result, exp_r);
    chk("fin_busy", 64'(busy), 64'd1);
    res = result;
    @(negedge clk);
    chk("ready_after", 64'(ready), 64'd1);
    chk("done_after", 64'(done), 64'd0);
    chk("result_held", result, exp_r);
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] prev;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        saw_done;

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    resetn = 1'b1;

    run_op(MD_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, res);
    chk("mul_7_m3", res, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(MD_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, res);
    chk("div_m7_2", res, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(MD_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, res);
    chk("rem_m7_2", res, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(MD_DIVU, 1'b0, 64'h1234, 64'd0, 1'b0, res);
    chk("divu_by0", res, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(MD_REMU, 1'b0, 64'h1234, 64'd0, 1'b0, res);
    chk("remu_by0", res, 64'h1234);
    run_op(MD_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, res);
    chk("div_ovf", res, 64'h8000_0000_0000_0000);
    run_op(MD_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, res);
    chk("rem_ovf", res, 64'd0);
    run_op(MD_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 1'b0, res);
    chk("mulw", res, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(MD_DIVU, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2, 1'b0, res);
    chk("divuw", res, 64'h0000_0000_4000_0000);

    // Flush in cycle 10 of a divide.
    prev = result;
    @(negedge clk);
    op = MD_DIV; word = 1'b0; src_a = 64'd100; src_b = 64'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; saw_done = done;
    repeat (9) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", 64'(ready), 64'd1);
    chk("flush_no_done", 64'(saw_done | done), 64'd0);
    chk("flush_result", result, prev);

    // Start together with flush is dropped.
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_ready", 64'(ready), 64'd1);
    chk("flush_start_busy", 64'(busy), 64'd0);

    run_op(MD_DIV, 1'b0, 64'd100, 64'd7, 1'b1, res);
    chk("div_100_7", res, 64'd14);

    // Reset asserted mid-op clears everything immediately.
    @(negedge clk);
    op = MD_DIV; src_a = 64'd100; src_b = 64'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(ready), 64'd1);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(5, 0))
        0: rb = 64'd0;
        1: begin ra = 64'h8000_0000_0000_0000; rb = 64'hFFFF_FFFF_FFFF_FFFF; end
        2: begin ra = 64'hFFFF_FFFF_8000_0000; rb = 64'hFFFF_FFFF_FFFF_FFFF; end
        3: rb = rb >> $urandom_range(60, 30);
        default: rb = rb;
      endcase
      run_op(md_op_t'($urandom_range(4, 0)), 1'($urandom), ra, rb, 1'b1, res);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative RV64M multiply/divide unit in the execute stage. Consumes the already-selected ALU operands (operand A and operand B) and produces one 64-bit result after a multi-cycle computation. Holds the pipeline via busy while it works. Sits beside the single-cycle ALU and feeds the same execute-result mux.

Parameters:
XLEN, 64, datapath width; only 64 is supported.

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous, active-low reset
start  in  1  request; accepted only when ready=1
op  in  3 (md_op_t)  MD_MUL, MD_DIV, MD_DIVU, MD_REM, MD_REMU
word  in  1  1 = *W variant (32-bit op, sign-extended result)
src_a  in  XLEN  operand A (rs1 value)
src_b  in  XLEN  operand B (rs2 value)
flush  in  1  synchronous abort of any in-flight op
ready  out  1  unit idle, may accept start
busy  out  1  op in flight or result pending; stalls the pipeline
done  out  1  one-cycle pulse; result valid this cycle
result  out  XLEN  result, held until the next accept

Behaviour:
- Reset: asynchronous assert while resetn=0 → state IDLE, ready=1, busy=0, done=0, result=0, all internal registers 0. Reset mid-op discards the op.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE→MUL: start and op=MD_MUL. IDLE→DIV: start and a div/rem op.
  - IDLE→FIN: special div case.
  - MUL/DIV→FIN when iteration counter reaches ITER-1.
  - FIN→IDLE always.
- ready = (state==IDLE); busy = !ready.
- done = (state==FIN). result is registered on the FIN cycle.
- Latency:
  - Acceptance edge is cycle 0.
  - ITER = 64 for doubleword ops, 32 for word ops.
  - done is high during cycle ITER+1: 65 for doubleword, 33 for word.
  - Special div cases: done during cycle 1.
- Operand prep at accept:
  - word=1: signed ops (MUL, DIV, REM) sign-extend src[31:0]; DIVU/REMU zero-extend.
  - word=0: full 64 bits.
- MUL:
  - Radix-2 shift-add, one bit per cycle.
  - Result is the low XLEN bits of the product; identical for signed and unsigned.
- DIV/REM:
  - Signed ops use absolute values, then an unsigned restoring divide, one quotient bit per cycle.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, decided at accept with no iteration (widths per word flag):
  - Divisor=0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend; remainder = 0.
- Word ops: result = sign-extend of 32-bit result[31:0]. This applies to DIVUW/REMUW too, per ISA.
- flush=1 has top priority over start, state and reset-release:
  - Next state IDLE; done never asserted for the aborted op; result unchanged.
  - flush with start in the same cycle: start is ignored.
- start while busy is ignored; operand/op changes while busy are ignored.
- Back-to-back: a start in the cycle after FIN (IDLE) is accepted normally. There is no accept in the FIN cycle itself.

Decomposition:
- Shared package common:
  - md_op_t enum (3-bit): MD_MUL=0, MD_DIV=1, MD_DIVU=2, MD_REM=3, MD_REMU=4.
  - md_state_t enum.
  - XLEN constant.
- Sub-module md_divider: unsigned restoring divider core (start, ITER, dividend, divisor → quotient, remainder, done).
- The multiplier, sign handling and FSM stay in mul_div_unit.

Test Plan:
1. MUL, word=0, src_a=7, src_b=0xFFFF_FFFF_FFFF_FFFD → done at cycle 65, result=0xFFFF_FFFF_FFFF_FFEB; busy=1 for cycles 1–65.
2. DIV and REM, src_a=0xFFFF_FFFF_FFFF_FFF9 (−7), src_b=2 → DIV result 0xFFFF_FFFF_FFFF_FFFD; REM result 0xFFFF_FFFF_FFFF_FFFF; each done at cycle 65.
3. DIVU src_a=0x1234, src_b=0 → done at cycle 1, result=0xFFFF_FFFF_FFFF_FFFF. REMU with the same operands → result=0x1234.
4. DIV src_a=0x8000_0000_0000_0000, src_b=−1 → result=0x8000_0000_0000_0000; REM → 0; both done at cycle 1.
5. Word ops:
   - MUL word=1, src_a=0x7FFF_FFFF, src_b=2 → done at cycle 33, result=0xFFFF_FFFF_FFFF_FFFE.
   - DIVU word=1, src_a=0xFFFF_FFFF_8000_0000, src_b=2 → result=0x0000_0000_4000_0000.
6. DIV 100/7:
   - flush at cycle 10 → ready=1 at cycle 11, no done pulse, result unchanged.
   - Restart: new start → done at cycle 65 with result 14.
   - Separately, resetn=0 at cycle 20 → all outputs 0 / IDLE immediately.
